reset_sequencer: RTL and testbench

// - Parametrised power-on/soft reset sequencer for the MC14500B core and its peripherals.
// - After reset release, asserts one reset pulse per channel inside a programmable cycle window.
// - Any channel can optionally be retimed half a cycle (negedge), as the PC reset is.
// - Adds a req/ack soft-restart of the whole sequence and busy/done status.
// - Defaults reproduce the current core timing: ch0 = pc_reset (half-phase), ch1 = icu_reset.

---
 rtl/reset_sequencer_pkg.sv | 26 ++
 rtl/reset_sequencer_if.sv | 11 +
 rtl/reset_sequencer_channel.sv | 39 +++
 rtl/reset_sequencer.sv | 97 +++++++++
 tb/tb_reset_sequencer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the reset sequencer: FSM states, window compare,
// and field extraction from the packed per-channel START/LEN parameters.
package reset_seq_pkg;

  typedef enum logic {
    SEQ_RUN  = 1'b0,
    SEQ_DONE = 1'b1
  } seq_state_e;

  // True when cnt lies in the half-open window [start, start+len); len 0 never matches.
  function automatic logic in_window(input int unsigned cnt,
                                     input int unsigned start,
                                     input int unsigned len);
    return (cnt >= start) && (cnt < start + len);
  endfunction

  // Extract field idx of width w from a packed vector (callers size-cast to 256 bits).
  function automatic int unsigned field(input logic [255:0] vec,
                                        input int unsigned  idx,
                                        input int unsigned  w);
    logic [255:0] sh;
    sh = vec >> (idx * w);
    return 32'(sh) & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Soft-restart handshake, status and per-channel reset outputs of the sequencer.
interface reset_sequencer_if #(parameter int NUM_CH = 2);
  logic              soft_req;
  logic              soft_ack;
  logic              seq_busy;
  logic              seq_done;
  logic [NUM_CH-1:0] ch_reset;

  modport master (output soft_req, input soft_ack, seq_busy, seq_done, ch_reset);
  modport slave  (input soft_req, output soft_ack, seq_busy, seq_done, ch_reset);
endinterface

// File: rtl/reset_sequencer_channel.sv
// One reset channel: registered window compare on the pre-increment count,
// with an optional negedge retime stage for half-phase channels.
module reset_seq_channel
  import reset_seq_pkg::*;
#(
  parameter int unsigned CNT_W      = 3,
  parameter int unsigned START      = 2,
  parameter int unsigned LEN        = 2,
  parameter logic        HALF_PHASE = 1'b0,
  parameter logic        HOLD       = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] cnt,
  input  logic             clear,
  output logic             ch_reset
);

  logic win;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      win <= HOLD;
    else if (clear) win <= 1'b0;
    else            win <= in_window(32'(cnt), START, LEN);
  end

  if (HALF_PHASE) begin : g_half
    logic win_neg;
    // Retime flop also resets to HOLD so the output is correct the instant reset rises.
    always_ff @(negedge clk or posedge reset) begin
      if (reset) win_neg <= HOLD;
      else       win_neg <= win;
    end
    assign ch_reset = win_neg;
  end else begin : g_full
    assign ch_reset = win;
  end

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer top: saturating sequence counter, run/done FSM with soft
// restart handshake, and one window channel per reset output.
//   state    | meaning
//   SEQ_RUN  | counter advancing toward SEQ_LEN, channel windows active
//   SEQ_DONE | counter saturated; a sampled soft_req restarts the sequence
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int                       NUM_CH        = 2,
  parameter int                       CNT_W         = 3,
  parameter int                       SEQ_LEN       = 4,
  parameter logic [NUM_CH*CNT_W-1:0]  START         = {3'd2, 3'd2},
  parameter logic [NUM_CH*CNT_W-1:0]  LEN           = {3'd2, 3'd2},
  parameter logic [NUM_CH-1:0]        HALF_PHASE    = 2'b01,
  parameter logic [NUM_CH-1:0]        HOLD_IN_RESET = 2'b00
) (
  input  logic              clk,
  input  logic              reset,
  reset_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] SEQ_END = CNT_W'(SEQ_LEN);

  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("reset_sequencer: NUM_CH must be at least 1");
  end
  if (SEQ_LEN >= 2**CNT_W) begin : g_bad_seq_len
    $error("reset_sequencer: SEQ_LEN does not fit in CNT_W bits");
  end

  seq_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             seq_done;
  logic             soft_ack;
  logic             accept;
  logic [NUM_CH-1:0] ch_vec;

  assign accept = (state == SEQ_DONE) && bus.soft_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= SEQ_RUN;
      cnt      <= '0;
      seq_done <= 1'b0;
      soft_ack <= 1'b0;
    end else begin
      soft_ack <= 1'b0;
      case (state)
        SEQ_RUN: begin
          if (cnt < SEQ_END) cnt <= cnt + 1'b1;
          if (cnt == SEQ_END) begin
            seq_done <= 1'b1;
            state    <= SEQ_DONE;
          end
        end
        SEQ_DONE: begin
          if (bus.soft_req) begin
            cnt      <= '0;
            seq_done <= 1'b0;
            soft_ack <= 1'b1;
            state    <= SEQ_RUN;
          end
        end
        default: state <= SEQ_RUN;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam int unsigned CH_START = field(256'(START), i, CNT_W);
    localparam int unsigned CH_LEN   = field(256'(LEN), i, CNT_W);

    if (CH_START + CH_LEN > SEQ_LEN) begin : g_bad_window
      $error("reset_sequencer: channel window extends past SEQ_LEN");
    end

    reset_seq_channel #(
      .CNT_W      (CNT_W),
      .START      (CH_START),
      .LEN        (CH_LEN),
      .HALF_PHASE (HALF_PHASE[i]),
      .HOLD       (HOLD_IN_RESET[i])
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .cnt      (cnt),
      .clear    (accept),
      .ch_reset (ch_vec[i])
    );
  end

  assign bus.ch_reset = ch_vec;
  assign bus.soft_ack = soft_ack;
  assign bus.seq_done = seq_done;
  assign bus.seq_busy = ~seq_done;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: a default 2-channel instance and a
// 3-channel instance share reset/soft_req; a cycle-age model predicts outputs.
module tb_reset_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic soft_req = 1'b0;

  always #5 clk = ~clk;

  reset_sequencer_if #(.NUM_CH(2)) bus_a ();
  reset_sequencer_if #(.NUM_CH(3)) bus_b ();

  assign bus_a.soft_req = soft_req;
  assign bus_b.soft_req = soft_req;

  reset_sequencer dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  reset_sequencer #(
    .NUM_CH        (3),
    .CNT_W         (4),
    .SEQ_LEN       (8),
    .START         ({4'd6, 4'd2, 4'd0}),
    .LEN           ({4'd2, 4'd3, 4'd1}),
    .HALF_PHASE    (3'b100),
    .HOLD_IN_RESET (3'b011)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  // Reference configuration, channel 0 first.
  int   seq_len [2]    = '{4, 8};
  int   nch     [2]    = '{2, 3};
  int   st      [2][3] = '{'{2, 2, 0}, '{0, 2, 6}};
  int   ln      [2][3] = '{'{2, 2, 0}, '{1, 3, 2}};
  logic hp      [2][3] = '{'{1'b1, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b1}};
  logic hold    [2][3] = '{'{1'b0, 1'b0, 1'b0}, '{1'b1, 1'b1, 1'b0}};

  // Model: age = posedges since release or last accept.
  logic in_rst;
  int   age    [2];
  logic done_m [2];
  logic ack_m  [2];
  logic win_m  [2][3];
  logic neg_m  [2][3];

  typedef struct packed {
    logic [2:0] ch_a;
    logic       ack_a, done_a, busy_a;
    logic [2:0] ch_b;
    logic       ack_b, done_b, busy_b;
  } exp_t;

  exp_t q_pos[$];
  exp_t q_neg[$];

  int vectors = 0;
  int miscompares = 0;

  function automatic void m_reset();
    for (int d = 0; d < 2; d++) begin
      age[d] = 0; done_m[d] = 1'b0; ack_m[d] = 1'b0;
      for (int i = 0; i < 3; i++) begin
        win_m[d][i] = hold[d][i];
        neg_m[d][i] = hold[d][i];
      end
    end
  endfunction

  function automatic void m_negedge();
    if (in_rst) return;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 3; i++) neg_m[d][i] = win_m[d][i];
  endfunction

  function automatic void m_posedge(input logic req);
    int c;
    if (in_rst) return;
    for (int d = 0; d < 2; d++) begin
      if (done_m[d] && req) begin
        age[d] = 0; ack_m[d] = 1'b1; done_m[d] = 1'b0;
        for (int i = 0; i < 3; i++) win_m[d][i] = 1'b0;
      end else begin
        ack_m[d] = 1'b0;
        if (age[d] < 1000) age[d]++;
        c = (age[d] - 1 < seq_len[d]) ? age[d] - 1 : seq_len[d];
        for (int i = 0; i < 3; i++)
          win_m[d][i] = (c >= st[d][i]) && (c < st[d][i] + ln[d][i]);
        done_m[d] = (age[d] >= seq_len[d] + 1);
      end
    end
  endfunction

  function automatic exp_t snap();
    exp_t e;
    e = '0;
    for (int i = 0; i < 3; i++) begin
      if (i < nch[0]) e.ch_a[i] = hp[0][i] ? neg_m[0][i] : win_m[0][i];
      if (i < nch[1]) e.ch_b[i] = hp[1][i] ? neg_m[1][i] : win_m[1][i];
    end
    e.ack_a = ack_m[0]; e.done_a = done_m[0]; e.busy_a = ~done_m[0];
    e.ack_b = ack_m[1]; e.done_b = done_m[1]; e.busy_b = ~done_m[1];
    return e;
  endfunction

  // One cycle of stimulus, applied 2 ns after a posedge.
  task automatic cycle(input logic r, input logic s);
    @(posedge clk);
    #2;
    if (r && !reset) begin
      reset = 1'b1; in_rst = 1'b1; m_reset();
    end else if (!r && reset) begin
      reset = 1'b0; in_rst = 1'b0;
    end
    soft_req = s;
    m_negedge();
    q_neg.push_back(snap());
    m_posedge(s);
    q_pos.push_back(snap());
  endtask

  task automatic check(input string tag, input exp_t e);
    logic [2:0] act;
    act = {1'b0, bus_a.ch_reset};
    vectors++;
    if (act !== e.ch_a || bus_a.soft_ack !== e.ack_a ||
        bus_a.seq_done !== e.done_a || bus_a.seq_busy !== e.busy_a) begin
      miscompares++;
      $display("FAIL %s dut_a t=%0t got ch=%b ack=%b done=%b busy=%b expected ch=%b ack=%b done=%b busy=%b",
               tag, $time, act, bus_a.soft_ack, bus_a.seq_done, bus_a.seq_busy,
               e.ch_a, e.ack_a, e.done_a, e.busy_a);
    end
    vectors++;
    if (bus_b.ch_reset !== e.ch_b || bus_b.soft_ack !== e.ack_b ||
        bus_b.seq_done !== e.done_b || bus_b.seq_busy !== e.busy_b) begin
      miscompares++;
      $display("FAIL %s dut_b t=%0t got ch=%b ack=%b done=%b busy=%b expected ch=%b ack=%b done=%b busy=%b",
               tag, $time, bus_b.ch_reset, bus_b.soft_ack, bus_b.seq_done, bus_b.seq_busy,
               e.ch_b, e.ack_b, e.done_b, e.busy_b);
    end
  endtask

  initial begin : mon_pos
    forever begin
      @(posedge clk);
      #1;
      if (q_pos.size() > 0) check("after_posedge", q_pos.pop_front());
    end
  end

  initial begin : mon_neg
    forever begin
      @(negedge clk);
      #1;
      if (q_neg.size() > 0) check("after_negedge", q_neg.pop_front());
    end
  end

  initial begin : stim
    in_rst = 1'b0;
    m_reset();
    #1;
    reset = 1'b1;
    in_rst = 1'b1;

    // Power-on: reset for 3 cycles, then a full undisturbed sequence.
    repeat (3) cycle(1'b1, 1'b0);
    repeat (12) cycle(1'b0, 1'b0);

    // Single-cycle soft request while done, then let it replay.
    cycle(1'b0, 1'b1);
    repeat (12) cycle(1'b0, 1'b0);

    // Request while busy (sampled at posedge 2) is ignored.
    repeat (2) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    repeat (12) cycle(1'b0, 1'b0);

    // Reset mid-pulse (between posedges 3 and 4), then a full replay.
    cycle(1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b0);
    repeat (2) cycle(1'b1, 1'b0);
    repeat (12) cycle(1'b0, 1'b0);

    // Held soft request: periodic accepts.
    repeat (20) cycle(1'b0, 1'b1);
    repeat (12) cycle(1'b0, 1'b0);

    // Random traffic with occasional asynchronous resets.
    for (int n = 0; n < 400; n++)
      cycle($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0);

    @(posedge clk);
    #5;
    if (q_pos.size() != 0 || q_neg.size() != 0) begin
      miscompares++;
      $display("FAIL drain got pending=%0d expected 0", q_pos.size() + q_neg.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
